// File: rtl/key_event_sched.sv
// Frame-synchronous keyboard scheduler: decodes HID keycodes into seven game keys
// and serialises press/repeat/release events onto one valid/ready stream.
module key_event_sched #(
    parameter int         REPEAT_DELAY = 15,
    parameter int         REPEAT_RATE  = 4,
    parameter logic [6:0] REPEAT_MASK  = 7'b1111000,
    parameter int         CNT_W        = 6
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic [31:0] keycode,
    input  logic        ev_ready,
    output logic        ev_valid,
    output logic [2:0]  ev_code,
    output logic [1:0]  ev_kind,
    output logic [6:0]  held,
    output logic        overflow
);

    localparam logic [CNT_W-1:0] DLY = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RLD = CNT_W'(REPEAT_DELAY - REPEAT_RATE);

    typedef enum logic {IDLE, VALID} state_t;

    state_t           state, state_nxt;
    logic [6:0]       cur;
    logic [6:0]       press_set, rep_set, rel_set;
    logic [6:0]       pend_press, pend_rep, pend_rel;
    logic [6:0]       clr_p, clr_r, clr_l;
    logic [6:0]       sel_hot;
    logic [CNT_W-1:0] cnt     [7];
    logic [CNT_W-1:0] cnt_nxt [7];
    logic [2:0]       sel_code;
    logic [1:0]       sel_kind;
    logic             any_pend, load, take, ovf_hit;

    function automatic logic [7:0] key_code(input int k);
        case (k)
            0:       return 8'h28;
            1:       return 8'h2C;
            2:       return 8'h0B;
            3:       return 8'h1A;
            4:       return 8'h04;
            5:       return 8'h16;
            default: return 8'h07;
        endcase
    endfunction

    always_comb begin
        cur = '0;
        for (int k = 0; k < 7; k++)
            for (int b = 0; b < 4; b++)
                if (keycode[8*b +: 8] == key_code(k))
                    cur[k] = 1'b1;
    end

    // Repeat fires when the incremented count reaches the delay, then reloads
    // so the next repeat lands exactly REPEAT_RATE ticks later.
    always_comb begin
        press_set = '0;
        rel_set   = '0;
        rep_set   = '0;
        for (int k = 0; k < 7; k++) begin
            cnt_nxt[k] = cnt[k];
            if (frame_tick) begin
                if (cur[k] && !held[k]) begin
                    press_set[k] = 1'b1;
                    cnt_nxt[k]   = '0;
                end else if (!cur[k] && held[k]) begin
                    rel_set[k] = 1'b1;
                    cnt_nxt[k] = '0;
                end else if (cur[k] && cnt[k] < DLY) begin
                    cnt_nxt[k] = cnt[k] + CNT_W'(1);
                    if (REPEAT_MASK[k] && cnt_nxt[k] == DLY) begin
                        rep_set[k] = 1'b1;
                        cnt_nxt[k] = RLD;
                    end
                end
            end
        end
    end

    always_comb begin
        sel_code = '0;
        sel_kind = '0;
        for (int k = 6; k >= 0; k--) begin
            if (pend_press[k] || pend_rep[k] || pend_rel[k]) begin
                sel_code = 3'(k);
                sel_kind = pend_press[k] ? 2'b01 :
                           pend_rep[k]   ? 2'b10 : 2'b11;
            end
        end
        any_pend = |(pend_press | pend_rep | pend_rel);
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                load = 1'b1;
                if (any_pend)
                    state_nxt = VALID;
            end
            VALID: begin
                if (ev_ready) begin
                    load      = 1'b1;
                    state_nxt = any_pend ? VALID : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        take    = load && any_pend;
        sel_hot = 7'b1 << sel_code;
        clr_p   = (take && sel_kind == 2'b01) ? sel_hot : '0;
        clr_r   = (take && sel_kind == 2'b10) ? sel_hot : '0;
        clr_l   = (take && sel_kind == 2'b11) ? sel_hot : '0;
        ovf_hit = |((press_set & pend_press & ~clr_p) |
                    (rep_set   & pend_rep   & ~clr_r) |
                    (rel_set   & pend_rel   & ~clr_l));
    end

    assign ev_valid = (state == VALID);

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ev_code    <= '0;
            ev_kind    <= '0;
            held       <= '0;
            overflow   <= 1'b0;
            pend_press <= '0;
            pend_rep   <= '0;
            pend_rel   <= '0;
            for (int k = 0; k < 7; k++)
                cnt[k] <= '0;
        end else begin
            if (frame_tick)
                held <= cur;
            // A release cancels any repeat still waiting for the same key.
            pend_press <= (pend_press & ~clr_p) | press_set;
            pend_rep   <= ((pend_rep & ~clr_r) | rep_set) & ~rel_set;
            pend_rel   <= (pend_rel & ~clr_l) | rel_set;
            overflow   <= overflow | ovf_hit;
            for (int k = 0; k < 7; k++)
                cnt[k] <= cnt_nxt[k];
            if (take) begin
                ev_code <= sel_code;
                ev_kind <= sel_kind;
            end
        end
    end

endmodule
